// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit,
// with a four-phase Send/Sent handshake on the parallel side.
module uart_tx_parity #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sout,
  output logic       Sent,
  output logic       Busy
);

  localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_ACK   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             sout_q, sout_d;
  logic             sent_q, sent_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Send) begin
          shift_d  = Din;
          parity_d = (PARITY != 0) ? ~^Din : ^Din;
          idx_d    = 3'd0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        // The counter also restarts at every data-bit boundary inside DATA.
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_PAR;
        end
      end
      ST_PAR: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) state_d = ST_ACK;
      end
      ST_ACK: begin
        cnt_d = '0;
        if (!Send) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs follow the current state one cycle later, so nothing is
  // combinational from Send or Din.
  always_comb begin
    sout_d = 1'b1;
    sent_d = 1'b0;
    busy_d = 1'b0;
    case (state_q)
      ST_START: begin sout_d = 1'b0;       busy_d = 1'b1; end
      ST_DATA:  begin sout_d = shift_q[0]; busy_d = 1'b1; end
      ST_PAR:   begin sout_d = parity_q;   busy_d = 1'b1; end
      ST_STOP:  begin sout_d = 1'b1;       busy_d = 1'b1; end
      ST_ACK:   begin sent_d = 1'b1; end
      default:  begin sout_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      sout_q   <= 1'b1;
      sent_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      sout_q   <= sout_d;
      sent_q   <= sent_d;
      busy_q   <= busy_d;
    end
  end

  assign Sout = sout_q;
  assign Sent = sent_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: odd and even parity instances share stimulus and
// are compared against a frame model built from the byte value.
module tb_uart_tx_parity;

  localparam int B = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] din;
  logic       sout_odd, sent_odd, busy_odd;
  logic       sout_even, sent_even, busy_even;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_parity #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .Send(send), .Din(din),
    .Sout(sout_odd), .Sent(sent_odd), .Busy(busy_odd)
  );

  uart_tx_parity #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY(0)) u_even (
    .clk(clk), .rst(rst), .Send(send), .Din(din),
    .Sout(sout_even), .Sent(sent_even), .Busy(busy_even)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame bit idx (0 = start ... 10 = stop) for byte d.
  function automatic logic ref_bit(input logic [7:0] d, input bit odd, input int idx);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic so, input logic se, input logic bu);
    chk({tag, " sout_odd"},  {31'd0, sout_odd},  {31'd0, so});
    chk({tag, " sout_even"}, {31'd0, sout_even}, {31'd0, so});
    chk({tag, " sent"},      {30'd0, sent_odd, sent_even}, {30'd0, se, se});
    chk({tag, " busy"},      {30'd0, busy_odd, busy_even}, {30'd0, bu, bu});
  endtask

  // mode 0: hold Send `hold` cycles in ACK, drop, wait for Sent to fall.
  // mode 1: like 0 but return right after the drop so the next frame is back-to-back.
  // mode 2: drop Send during the frame; Sent pulses for one cycle.
  // abort_at >= 0: pulse rst during that frame bit and abandon the frame.
  task automatic send_frame(input logic [7:0] d, input int mode, input int hold,
                            input int abort_at, input bit swap, input logic [7:0] d_alt);
    int pos;
    string t;
    @(negedge clk);
    din  = d;
    send = 1'b1;
    tick();
    t = $sformatf("%02h accept", d);
    chk_all(t, 1'b1, 1'b0, 1'b0);
    tick();
    pos = 1;
    t = $sformatf("%02h start_edge", d);
    chk_all(t, 1'b0, 1'b0, 1'b1);
    if (swap) begin
      @(negedge clk);
      din = d_alt;
    end
    for (int i = 0; i < 11; i++) begin
      while (pos < 6 + B * i) begin
        tick();
        pos++;
      end
      t = $sformatf("%02h bit%0d", d, i);
      chk({t, " odd"},  {31'd0, sout_odd},  {31'd0, ref_bit(d, 1'b1, i)});
      chk({t, " even"}, {31'd0, sout_even}, {31'd0, ref_bit(d, 1'b0, i)});
      if (i == abort_at) begin
        @(negedge clk);
        rst  = 1'b1;
        send = 1'b0;
        tick();
        t = $sformatf("%02h abort", d);
        chk_all(t, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3 * B; c++) begin
          tick();
          if (c % 5 == 4) chk_all($sformatf("%02h post_abort c%0d", d, c), 1'b1, 1'b0, 1'b0);
        end
        $display("frame %02h aborted at bit %0d", d, i);
        return;
      end
      if (mode == 2 && i == 2) begin
        @(negedge clk);
        send = 1'b0;
      end
    end
    while (pos < 11 * B) begin
      tick();
      pos++;
    end
    chk_all($sformatf("%02h stop_end", d), 1'b1, 1'b0, 1'b1);
    tick();
    chk_all($sformatf("%02h sent_rise", d), 1'b1, 1'b1, 1'b0);
    if (mode == 2) begin
      tick();
      chk_all($sformatf("%02h sent_pulse_end", d), 1'b1, 1'b0, 1'b0);
    end else begin
      for (int c = 0; c < hold; c++) begin
        tick();
        chk_all($sformatf("%02h hold c%0d", d, c), 1'b1, 1'b1, 1'b0);
      end
      @(negedge clk);
      send = 1'b0;
      tick();
      chk_all($sformatf("%02h drop_seen", d), 1'b1, 1'b1, 1'b0);
      if (mode != 1) begin
        tick();
        chk_all($sformatf("%02h sent_fall", d), 1'b1, 1'b0, 1'b0);
      end
    end
    $display("frame %02h mode %0d hold %0d done", d, mode, hold);
  endtask

  initial begin
    logic [7:0] rd;
    int rmode, rhold;
    rst  = 1'b1;
    send = 1'b1;
    din  = 8'h55;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all($sformatf("reset c%0d", c), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst  = 1'b0;
    send = 1'b0;
    tick();
    chk_all("after_reset", 1'b1, 1'b0, 1'b0);
    $display("reset sequence done");

    send_frame(8'h41, 0, 0,  -1, 1'b0, 8'h00);
    send_frame(8'h07, 0, 2,  -1, 1'b0, 8'h00);
    send_frame(8'h00, 2, 0,  -1, 1'b0, 8'h00);
    send_frame(8'h5A, 1, 50, -1, 1'b0, 8'h00);
    send_frame(8'hC3, 0, 0,  -1, 1'b0, 8'h00);
    send_frame(8'hA5, 0, 0,  4,  1'b0, 8'h00);
    send_frame(8'h3C, 0, 0,  -1, 1'b0, 8'h00);
    send_frame(8'hF0, 0, 0,  -1, 1'b1, 8'h0F);

    for (int r = 0; r < 8; r++) begin
      rd    = 8'($urandom);
      rmode = $urandom_range(0, 2);
      rhold = $urandom_range(0, 5);
      send_frame(rd, rmode, rhold, -1, ($urandom_range(0, 1) == 1), 8'($urandom));
    end
    tick();
    tick();
    chk_all("final_idle", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
